// File: rtl/game_event_scheduler.sv
// game_event_scheduler
// Shares the slow game tick among NUM_CH periodic event channels, runs the
// level countdown and requests turbo pace near the end of a level. Due
// events are offered to the game controller one at a time over a
// valid/ready port, granted round-robin across channels.
module game_event_scheduler #(
   parameter  int NUM_CH    = 4,
   parameter  int CNT_W     = 8,
   parameter  int LEVEL_W   = 10,
   parameter  int TURBO_THR = 10,
   localparam int ID_W      = $clog2(NUM_CH)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    tick,
   input  logic                    start,
   input  logic                    pause_toggle,
   input  logic [LEVEL_W-1:0]      level_time,
   input  logic [NUM_CH-1:0]       ch_en,
   input  logic [NUM_CH*CNT_W-1:0] ch_period,
   input  logic                    evt_ready,
   output logic                    evt_valid,
   output logic [ID_W-1:0]         evt_id,
   output logic                    turbo,
   output logic [1:0]              state,
   output logic [LEVEL_W-1:0]      time_left,
   output logic                    time_up,
   output logic [NUM_CH-1:0]       overflow
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W:0]     CNT_ONE_EXT = (CNT_W+1)'(1);
   localparam logic [LEVEL_W-1:0] LVL_ONE     = LEVEL_W'(1);
   localparam logic [ID_W-1:0]    LAST_CH     = ID_W'(NUM_CH - 1);

   // Control state
   state_t               state_q;
   state_t               state_d;
   logic [LEVEL_W-1:0]   time_left_q;
   logic                 time_up_q;
   logic                 turbo_q;

   // Decoded per-cycle controls
   logic                 tick_run;     // tick that advances the level this cycle
   logic                 enter_done;   // level ends this cycle

   // Channel state
   logic [CNT_W-1:0]     cnt_q      [NUM_CH];
   logic [CNT_W-1:0]     cnt_d      [NUM_CH];
   logic [CNT_W-1:0]     period_eff [NUM_CH];
   logic [NUM_CH-1:0]    fire;
   logic [NUM_CH-1:0]    pending_q;
   logic [NUM_CH-1:0]    pending_d;
   logic [NUM_CH-1:0]    overflow_q;
   logic [NUM_CH-1:0]    overflow_d;

   // Arbiter and event port
   logic                 gnt_found;
   logic                 grant;
   logic [ID_W-1:0]      gnt_id;
   int                   scan_idx;
   logic [ID_W-1:0]      last_q;
   logic                 evt_valid_q;
   logic [ID_W-1:0]      evt_id_q;

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------

   // State register
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of block evaluation order.
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next state: start beats pause_toggle beats tick; a zero-length level
   // finishes on the first RUN cycle without waiting for a tick.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned and infers a latch.
      state_d = state_q;
      if (start) begin
         state_d = ST_RUN;
      end else begin
         unique case (state_q)
            ST_RUN: begin
               if (time_left_q == '0)
                  state_d = ST_DONE;
               else if (pause_toggle)
                  state_d = ST_PAUSE;
               else if (tick && time_left_q == LVL_ONE)
                  state_d = ST_DONE;
            end
            ST_PAUSE: begin
               if (pause_toggle) state_d = ST_RUN;
            end
            default: ;
         endcase
      end
   end

   // FSM outputs: which tick counts and whether the level ends now
   always_comb begin
      tick_run   = 1'b0;
      enter_done = 1'b0;
      if (!start && state_q == ST_RUN) begin
         tick_run   = tick && !pause_toggle && (time_left_q != '0);
         enter_done = (state_d == ST_DONE);
      end
   end

   // ------------------------------------------------------------------
   // Level countdown and turbo
   // ------------------------------------------------------------------

   // Countdown, end-of-level pulse and turbo request (turbo lags time_left by one cycle)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         time_left_q <= '0;
         time_up_q   <= 1'b0;
         turbo_q     <= 1'b0;
      end else begin
         time_up_q <= enter_done;
         turbo_q   <= (state_q == ST_RUN) &&
                      (32'(time_left_q) <= 32'(TURBO_THR)) &&
                      (time_left_q != '0);
         if (start)
            time_left_q <= level_time;
         else if (tick_run)
            time_left_q <= time_left_q - LVL_ONE;
      end
   end

   // ------------------------------------------------------------------
   // Channels
   // ------------------------------------------------------------------

   // Per-channel fire decision; compare is one bit wider so counter+1 never wraps
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         period_eff[i] = (ch_period[i*CNT_W +: CNT_W] == '0) ? CNT_ONE
                                                               : ch_period[i*CNT_W +: CNT_W];
         fire[i]       = (({1'b0, cnt_q[i]} + CNT_ONE_EXT) >= {1'b0, period_eff[i]});
      end
   end

   // Channel next state: disabled channels are held clear; a tick set beats a same-cycle grant clear
   always_comb begin
      cnt_d      = cnt_q;
      pending_d  = pending_q;
      overflow_d = overflow_q;
      if (start) begin
         for (int i = 0; i < NUM_CH; i++) cnt_d[i] = '0;
         pending_d  = '0;
         overflow_d = '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (!ch_en[i]) begin
               cnt_d[i]     = '0;
               pending_d[i] = 1'b0;
            end else begin
               if (grant && gnt_id == ID_W'(i))
                  pending_d[i] = 1'b0;
               if (tick_run) begin
                  if (fire[i]) begin
                     cnt_d[i]     = '0;
                     pending_d[i] = 1'b1;
                     if (pending_q[i] && !(grant && gnt_id == ID_W'(i)))
                        overflow_d[i] = 1'b1;
                  end else begin
                     cnt_d[i] = cnt_q[i] + CNT_ONE;
                  end
               end
            end
         end
      end
   end

   // Channel registers
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: the counter array is tiny and architecturally visible, so it is
      // reset like any other register rather than treated as an unreset memory.
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
         pending_q  <= '0;
         overflow_q <= '0;
      end else begin
         cnt_q      <= cnt_d;
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
      end
   end

   // ------------------------------------------------------------------
   // Round-robin arbiter and event port
   // ------------------------------------------------------------------

   // Pick the first pending channel after the last granted one; grant only in RUN when the port is free
   always_comb begin
      gnt_found = 1'b0;
      gnt_id    = last_q;
      scan_idx  = 0;
      for (int k = 1; k <= NUM_CH; k++) begin
         scan_idx = (int'(last_q) + k) % NUM_CH;
         if (!gnt_found && pending_q[scan_idx]) begin
            gnt_found = 1'b1;
            gnt_id    = ID_W'(scan_idx);
         end
      end
      grant = gnt_found && !start && (state_q == ST_RUN) &&
              (!evt_valid_q || evt_ready);
   end

   // Event port: start aborts the offer, a grant loads a new one, acceptance alone drops valid
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         evt_valid_q <= 1'b0;
         evt_id_q    <= '0;
         last_q      <= LAST_CH;
      end else if (start) begin
         evt_valid_q <= 1'b0;
      end else if (grant) begin
         evt_valid_q <= 1'b1;
         evt_id_q    <= gnt_id;
         last_q      <= gnt_id;
      end else if (evt_valid_q && evt_ready) begin
         evt_valid_q <= 1'b0;
      end
   end

   assign evt_valid = evt_valid_q;
   assign evt_id    = evt_id_q;
   assign turbo     = turbo_q;
   assign state     = state_q;
   assign time_left = time_left_q;
   assign time_up   = time_up_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_game_event_scheduler.sv
// tb_game_event_scheduler
// Directed scenarios plus a randomized run, all compared every cycle against
// a behavioural model of the scheduler kept in plain integers and arrays.
module tb_game_event_scheduler;

   localparam int NUM_CH    = 4;
   localparam int CNT_W     = 8;
   localparam int LEVEL_W   = 10;
   localparam int TURBO_THR = 10;
   localparam int ID_W      = $clog2(NUM_CH);

   localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

   logic                    clk = 1'b0;
   logic                    reset;
   logic                    tick, start, pause_toggle, evt_ready;
   logic [LEVEL_W-1:0]      level_time;
   logic [NUM_CH-1:0]       ch_en;
   logic [NUM_CH*CNT_W-1:0] ch_period;
   logic                    evt_valid;
   logic [ID_W-1:0]         evt_id;
   logic                    turbo;
   logic [1:0]              state;
   logic [LEVEL_W-1:0]      time_left;
   logic                    time_up;
   logic [NUM_CH-1:0]       overflow;

   always #5 clk = ~clk;

   game_event_scheduler #(
      .NUM_CH(NUM_CH), .CNT_W(CNT_W), .LEVEL_W(LEVEL_W), .TURBO_THR(TURBO_THR)
   ) dut (
      .clk(clk), .reset(reset), .tick(tick), .start(start),
      .pause_toggle(pause_toggle), .level_time(level_time), .ch_en(ch_en),
      .ch_period(ch_period), .evt_ready(evt_ready), .evt_valid(evt_valid),
      .evt_id(evt_id), .turbo(turbo), .state(state), .time_left(time_left),
      .time_up(time_up), .overflow(overflow)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   int m_state, m_time, m_last, m_id;
   bit m_valid, m_turbo, m_time_up;
   int m_cnt  [NUM_CH];
   bit m_pend [NUM_CH];
   bit m_ovf  [NUM_CH];

   task automatic model_reset();
      m_state = S_IDLE; m_time = 0; m_last = NUM_CH - 1; m_id = 0;
      m_valid = 0; m_turbo = 0; m_time_up = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         m_cnt[i] = 0; m_pend[i] = 0; m_ovf[i] = 0;
      end
   endtask

   task automatic model_step();
      bit grant, tick_eff, hit;
      int gid, c, p;
      grant = 0; gid = 0;
      if (!start && m_state == S_RUN && (!m_valid || evt_ready))
         for (int k = 1; k <= NUM_CH; k++) begin
            c = (m_last + k) % NUM_CH;
            if (!grant && m_pend[c]) begin grant = 1; gid = c; end
         end
      tick_eff  = !start && m_state == S_RUN && m_time != 0 && !pause_toggle && tick;
      m_turbo   = (m_state == S_RUN) && (m_time <= TURBO_THR) && (m_time != 0);
      m_time_up = 0;
      if (start) begin
         m_state = S_RUN; m_time = int'(level_time); m_valid = 0;
         for (int i = 0; i < NUM_CH; i++) begin
            m_cnt[i] = 0; m_pend[i] = 0; m_ovf[i] = 0;
         end
      end else begin
         if (m_state == S_RUN && m_time == 0) begin
            m_state = S_DONE; m_time_up = 1;
         end else if (pause_toggle && m_state == S_RUN) m_state = S_PAUSE;
         else if (pause_toggle && m_state == S_PAUSE) m_state = S_RUN;
         else if (tick_eff) begin
            m_time = m_time - 1;
            if (m_time == 0) begin m_state = S_DONE; m_time_up = 1; end
         end
         for (int i = 0; i < NUM_CH; i++) begin
            hit = grant && gid == i;
            if (!ch_en[i]) begin
               m_cnt[i] = 0; m_pend[i] = 0;
            end else begin
               p = int'(ch_period[i*CNT_W +: CNT_W]);
               if (p == 0) p = 1;
               if (tick_eff && m_cnt[i] + 1 >= p) begin
                  if (m_pend[i] && !hit) m_ovf[i] = 1;
                  m_cnt[i]  = 0;
                  m_pend[i] = 1;
               end else begin
                  if (tick_eff) m_cnt[i] = m_cnt[i] + 1;
                  if (hit) m_pend[i] = 0;
               end
            end
         end
         if (grant) begin
            m_valid = 1; m_id = gid; m_last = gid;
         end else if (m_valid && evt_ready) m_valid = 0;
      end
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) model_reset();
      else       model_step();
   end

   // ---------------- DUT-side observation ----------------
   int dut_acc [NUM_CH];
   int dut_time_up_count;

   always @(posedge clk)
      if (!reset && !start && evt_valid && evt_ready) dut_acc[evt_id]++;

   // Compare every output against the model on the falling edge
   always @(negedge clk) begin
      logic [NUM_CH-1:0] ovf_v;
      if (!reset) begin
         for (int i = 0; i < NUM_CH; i++) ovf_v[i] = m_ovf[i];
         check("state",     state,     m_state);
         check("time_left", time_left, m_time);
         check("time_up",   time_up,   m_time_up);
         check("turbo",     turbo,     m_turbo);
         check("evt_valid", evt_valid, m_valid);
         check("evt_id",    evt_id,    m_id);
         check("overflow",  overflow,  ovf_v);
         if (time_up) dut_time_up_count++;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(negedge clk); #1;
   endtask

   task automatic drive(input bit t, input bit s, input bit p);
      tick = t; start = s; pause_toggle = p;
      cyc();
      tick = 0; start = 0; pause_toggle = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc();
   endtask

   task automatic clear_acc();
      for (int i = 0; i < NUM_CH; i++) dut_acc[i] = 0;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      reset = 1; tick = 0; start = 0; pause_toggle = 0; evt_ready = 0;
      level_time = '0; ch_en = '0; ch_period = '0;
      dut_time_up_count = 0;
      clear_acc();
      idle(2);
      check("rst_state", state, 0);
      check("rst_valid", evt_valid, 0);
      check("rst_time_left", time_left, 0);
      reset = 0;
      idle(2);

      // Level of 5 ticks ends with one time_up pulse; later ticks ignored
      level_time = 10'd5;
      drive(0, 1, 0);
      check("t1_time_left_start", time_left, 5);
      for (int i = 0; i < 5; i++) begin drive(1, 0, 0); idle(1); end
      check("t1_state_done", state, S_DONE);
      check("t1_time_left_zero", time_left, 0);
      drive(1, 0, 0); drive(1, 0, 0);
      check("t1_still_done", state, S_DONE);
      check("t1_one_time_up", dut_time_up_count, 1);

      // Zero-length level: RUN, then DONE with a pulse on the next cycle
      level_time = 10'd0;
      drive(0, 1, 0);
      check("t1z_run", state, S_RUN);
      cyc();
      check("t1z_done", state, S_DONE);
      check("t1z_time_up", time_up, 1);

      // Periods 1,2,3,4 with ready high: 12 ticks give 12/6/4/3 events
      ch_en = 4'hF; ch_period = {8'd4, 8'd3, 8'd2, 8'd1};
      evt_ready = 1; level_time = 10'd100;
      drive(0, 1, 0);
      clear_acc();
      for (int i = 0; i < 12; i++) begin drive(1, 0, 0); idle(7); end
      check("t2_cnt_ch0", dut_acc[0], 12);
      check("t2_cnt_ch1", dut_acc[1], 6);
      check("t2_cnt_ch2", dut_acc[2], 4);
      check("t2_cnt_ch3", dut_acc[3], 3);
      check("t2_no_overflow", overflow, 0);

      // Ready low: event held stable, overflow after the 2nd extra tick
      ch_en = 4'b0001; ch_period = {8'd4, 8'd3, 8'd2, 8'd1};
      evt_ready = 0;
      drive(0, 1, 0);
      drive(1, 0, 0); idle(2);
      check("t3_held_valid", evt_valid, 1);
      drive(1, 0, 0); idle(1);
      check("t3_ovf_after_1", overflow, 0);
      drive(1, 0, 0); idle(1);
      check("t3_ovf_after_2", overflow, 1);
      check("t3_held_id", evt_id, 0);
      drive(1, 0, 0); idle(1);
      check("t3_still_valid", evt_valid, 1);
      clear_acc();
      evt_ready = 1;
      idle(4);
      check("t3_delivered", dut_acc[0], 2);
      check("t3_drained", evt_valid, 0);

      // Pause at time_left 7: countdown frozen, held event stays, no grants
      evt_ready = 0; level_time = 10'd20;
      drive(0, 1, 0);
      for (int i = 0; i < 13; i++) begin drive(1, 0, 0); idle(1); end
      check("t4_time7", time_left, 7);
      drive(0, 0, 1);
      check("t4_paused", state, S_PAUSE);
      for (int i = 0; i < 4; i++) begin drive(1, 0, 0); idle(1); end
      check("t4_time_frozen", time_left, 7);
      check("t4_held", evt_valid, 1);
      evt_ready = 1; cyc(); evt_ready = 0; idle(2);
      check("t4_no_grant_paused", evt_valid, 0);
      drive(0, 0, 1);
      idle(1);
      check("t4_grant_after_resume", evt_valid, 1);

      // Turbo: rises the cycle after time_left reaches 10, falls after DONE
      ch_en = '0; evt_ready = 1; level_time = 10'd15;
      drive(0, 1, 0);
      for (int i = 0; i < 4; i++) begin drive(1, 0, 0); idle(1); end
      drive(1, 0, 0);
      check("t5_time10", time_left, 10);
      check("t5_turbo_lag", turbo, 0);
      cyc();
      check("t5_turbo_on", turbo, 1);
      for (int i = 0; i < 10; i++) begin drive(1, 0, 0); idle(1); end
      check("t5_done", state, S_DONE);
      check("t5_turbo_off", turbo, 0);

      // Restart mid-run with an offer outstanding and pending bits set
      ch_en = 4'hF; ch_period = {8'd1, 8'd1, 8'd1, 8'd1};
      evt_ready = 0; level_time = 10'd50;
      drive(0, 1, 0);
      drive(1, 0, 0); idle(2);
      drive(1, 0, 0); idle(1);
      level_time = 10'd33;
      drive(0, 1, 0);
      check("t6_valid_abort", evt_valid, 0);
      check("t6_ovf_clear", overflow, 0);
      check("t6_time_reload", time_left, 33);
      check("t6_state_run", state, S_RUN);
      drive(1, 0, 0); idle(2);
      drive(1, 0, 0); idle(1);
      reset = 1; #1;
      check("t6_rst_state", state, 0);
      check("t6_rst_valid", evt_valid, 0);
      check("t6_rst_id", evt_id, 0);
      check("t6_rst_time", time_left, 0);
      check("t6_rst_ovf", overflow, 0);
      check("t6_rst_turbo", turbo, 0);
      idle(2);
      reset = 0;
      idle(1);

      // Randomized run
      for (int n = 0; n < 3000; n++) begin
         if (n % 50 == 0) begin
            ch_en      = NUM_CH'($urandom);
            for (int i = 0; i < NUM_CH; i++)
               ch_period[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 5));
            level_time = LEVEL_W'($urandom_range(0, 30));
         end
         if (n == 1500) begin reset = 1; idle(2); reset = 0; end
         tick         = ($urandom_range(0, 2) == 0);
         start        = ($urandom_range(0, 96) == 0) || (n == 0);
         pause_toggle = ($urandom_range(0, 28) == 0);
         evt_ready    = ($urandom_range(0, 9) < 7);
         cyc();
      end
      tick = 0; start = 0; pause_toggle = 0;
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
